// File: rtl/mem_dma_master.sv
// Block-copy bus master: reads len words from src and writes them to dst over the shared memory bus.
// Optional fill mode (macro MEM_DMA_FILL_EN) writes a constant to dst..dst+len-1 and skips all reads.
module mem_dma_master #(
  parameter int AW     = 9,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
`ifdef MEM_DMA_FILL_EN
  input  logic          fill,
  input  logic [DW-1:0] fill_value,
`endif
  input  logic          bus_gnt,
  input  logic [DW-1:0] read_data,
  output logic          bus_req,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] write_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] remaining
);

  localparam logic [1:0] MREAD  = 2'd1;
  localparam logic [1:0] MNONE  = 2'd2;
  localparam logic [1:0] MWRITE = 2'd3;

  localparam int LW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [LW-1:0] LAT_MAX = LW'(RD_LAT);
  localparam logic [LW-1:0] LAT_ONE = LW'(1);
  localparam logic [AW-1:0] ONE     = AW'(1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] src_ptr, dst_ptr, rem;
  logic [DW-1:0] dat;
  logic [LW-1:0] lat_cnt;
  logic          fill_q;
  logic          fill_go;
  logic          rd_last;
  logic          wr_fire;

  assign remaining = rem;

  always_comb begin
    state_nxt  = state;
    bus_req    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    mem_cmd    = MNONE;
    mem_addr   = src_ptr;
    write_data = dat;
    rd_last    = 1'b0;
    wr_fire    = 1'b0;
    fill_go    = 1'b0;
`ifdef MEM_DMA_FILL_EN
    fill_go    = fill;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0)   state_nxt = DONE;
          else if (fill_go) state_nxt = WR;
          else              state_nxt = RD;
        end
      end
      RD: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        // A dropped grant abandons the read; the counter restarts from zero.
        if (bus_gnt) begin
          mem_cmd = MREAD;
          if (lat_cnt == LAT_MAX) begin
            rd_last   = 1'b1;
            state_nxt = WR;
          end
        end
      end
      WR: begin
        bus_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = dst_ptr;
        if (bus_gnt) begin
          mem_cmd = MWRITE;
          wr_fire = 1'b1;
          if (rem == ONE)  state_nxt = DONE;
          else if (fill_q) state_nxt = WR;
          else             state_nxt = RD;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      rem     <= '0;
      dat     <= '0;
      lat_cnt <= '0;
      fill_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src;
            dst_ptr <= dst;
            rem     <= len;
            lat_cnt <= '0;
            fill_q  <= fill_go;
`ifdef MEM_DMA_FILL_EN
            // Fill mode reuses the data register as the constant source.
            if (fill) dat <= fill_value;
`endif
          end
        end
        RD: begin
          if (!bus_gnt || rd_last) lat_cnt <= '0;
          else                     lat_cnt <= lat_cnt + LAT_ONE;
          if (rd_last) dat <= read_data;
        end
        WR: begin
          if (wr_fire) begin
            src_ptr <= src_ptr + ONE;
            dst_ptr <= dst_ptr + ONE;
            rem     <= rem - ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma_master.sv
// Bench for mem_dma_master: RAM/I-O responder, write scoreboard fed from a memory model, bus monitor.
module tb_mem_dma_master;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int RD_LAT = 1;
  localparam logic [15:0] SW = 16'h0C3A;

  typedef struct packed {
    logic [8:0]  a;
    logic [15:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src = '0, dst = '0, len = '0;
  logic          bus_gnt = 1'b1;
  logic [DW-1:0] read_data = '0;
  logic          bus_req, busy, done;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr, remaining;
  logic [DW-1:0] write_data;
`ifdef MEM_DMA_FILL_EN
  logic          fill = 1'b0;
  logic [DW-1:0] fill_value = '0;
`endif

  mem_dma_master #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
`ifdef MEM_DMA_FILL_EN
    .fill(fill), .fill_value(fill_value),
`endif
    .bus_gnt(bus_gnt), .read_data(read_data), .bus_req(bus_req), .mem_cmd(mem_cmd),
    .mem_addr(mem_addr), .write_data(write_data), .busy(busy), .done(done),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Responder: registered RAM below 0x100, LED at 0x100, switches at 0x140.
  logic [15:0] ram [256];
  logic [15:0] model [256];
  logic [15:0] led = '0;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_a = '0;
  logic [15:0] pre_d = '0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (mem_cmd == 2'd3) begin
      if (!mem_addr[8]) ram[mem_addr[7:0]] <= write_data;
      else if (mem_addr == 9'h100) led <= write_data;
    end
    read_data <= mem_addr[8] ? ((mem_addr == 9'h140) ? SW : 16'h0) : ram[mem_addr[7:0]];
  end

  function automatic logic [15:0] model_rd(input logic [8:0] a);
    if (a[8]) return (a == 9'h140) ? SW : 16'h0;
    return model[a[7:0]];
  endfunction

  // Bus monitor and scoreboard.
  wr_t        wrq[$];
  logic [8:0] rdq[$];
  int cyc = 0, s_cyc = 0, done_cyc = 0;
  int n_rd = 0, n_wr = 0, n_busy = 0, n_done = 0, n_bad = 0, run = 0, last_run = 0;
  logic chk_run = 1'b1;

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (mem_cmd == 2'd0 || (!bus_gnt && mem_cmd != 2'd2)) n_bad++;
    if (mem_cmd == 2'd1) begin
      if (run == 0 && rdq.size() > 0) chk("rd_addr", 32'(mem_addr), 32'(rdq.pop_front()));
      run++;
      n_rd++;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (mem_cmd == 2'd3) begin
      n_wr++;
      if (chk_run) chk("rd_run", 32'(last_run), 32'(1 + RD_LAT));
      if (wrq.size() > 0) begin
        e = wrq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", 32'(write_data), 32'(e.d));
      end
    end
    if (busy) n_busy++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    model[a] = d;
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(posedge clk); #1 pre_we = 1'b0;
  endtask

  task automatic start_xfer(input logic [8:0] s, input logic [8:0] d, input logic [8:0] l,
                            input logic f, input logic [15:0] fv, input logic trk);
    logic [8:0]  sa, da;
    logic [15:0] v;
    for (int i = 0; i < int'(l); i++) begin
      sa = s + 9'(i);
      da = d + 9'(i);
      v  = f ? fv : model_rd(sa);
      if (!da[8]) model[da[7:0]] = v;
      wrq.push_back('{a: da, d: v});
      if (trk && !f) rdq.push_back(sa);
    end
    @(posedge clk); #1;
    src = s; dst = d; len = l; start = 1'b1;
`ifdef MEM_DMA_FILL_EN
    fill = f; fill_value = fv;
`endif
    @(negedge clk); #1 s_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int off);
    int dn;
    dn = n_done;
    for (int i = 0; i < 400 && n_done == dn; i++) begin
      @(negedge clk); #1;
    end
    chk({tag, "_done_seen"}, 32'(n_done - dn), 32'd1);
    chk({tag, "_done_lat"}, 32'(done_cyc - s_cyc), 32'(off));
    @(negedge clk); #1 chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic wait_cmd(input logic [1:0] c, input logic twice);
    logic prev;
    prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (mem_cmd == c) begin
        if (!twice || prev) break;
        prev = 1'b1;
      end else prev = 1'b0;
    end
  endtask

  initial begin
    int nr, nw, nb;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_cmd", 32'(mem_cmd), 32'd2);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(write_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_rem", 32'(remaining), 32'd0);
    for (int i = 0; i < 256; i++) poke(8'(i), 16'h1000 + 16'(i * 7));
    poke(8'h10, 16'h00A1); poke(8'h11, 16'h00B2); poke(8'h12, 16'h00C3); poke(8'h13, 16'h00D4);
    @(posedge clk); #1 reset = 1'b1;

    // Plain copy: 3 cycles per word, busy for 3*len+1.
    nw = n_wr; nb = n_busy;
    start_xfer(9'h010, 9'h020, 9'd4, 1'b0, 16'h0, 1'b0);
    wait_done("copy", 13);
    chk("copy_wr_cnt", 32'(n_wr - nw), 32'd4);
    chk("copy_busy_cnt", 32'(n_busy - nb), 32'd13);
    chk("copy_ram0", 32'(ram[8'h20]), 32'h00A1);
    chk("copy_ram1", 32'(ram[8'h21]), 32'h00B2);
    chk("copy_ram2", 32'(ram[8'h22]), 32'h00C3);
    chk("copy_ram3", 32'(ram[8'h23]), 32'h00D4);

    nr = n_rd; nw = n_wr;
    start_xfer(9'h050, 9'h070, 9'd0, 1'b0, 16'h0, 1'b0);
    wait_done("len0", 1);
    chk("len0_rd_cnt", 32'(n_rd - nr), 32'd0);
    chk("len0_wr_cnt", 32'(n_wr - nw), 32'd0);

    nw = n_wr;
    start_xfer(9'h1FE, 9'h0F0, 9'd3, 1'b0, 16'h0, 1'b1);
    wait_done("wrap", 10);
    chk("wrap_rdq_left", 32'(rdq.size()), 32'd0);
    chk("wrap_wr_cnt", 32'(n_wr - nw), 32'd3);
    chk("wrap_ram2", 32'(ram[8'hF2]), 32'(model[8'h00]));

    start_xfer(9'h030, 9'h031, 9'd3, 1'b0, 16'h0, 1'b0);
    wait_done("ovl", 10);
    for (int i = 1; i < 4; i++) chk("ovl_ram", 32'(ram[8'h30 + 8'(i)]), 32'(model[8'h30 + 8'(i)]));

    // Grant stalls during a read and during a write, with ignored start pulses.
    nw = n_wr;
    start_xfer(9'h040, 9'h060, 9'd3, 1'b0, 16'h0, 1'b0);
    wait_cmd(2'd1, 1'b0);
    @(posedge clk); #1 bus_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1 chk("stall_rd_cmd", 32'(mem_cmd), 32'd2);
      start = (i == 2); src = 9'h0AA; dst = 9'h0BB; len = 9'd5;
    end
    @(posedge clk); #1 bus_gnt = 1'b1; start = 1'b0;
    wait_cmd(2'd1, 1'b1);
    @(posedge clk); #1 bus_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1 chk("stall_wr_cmd", 32'(mem_cmd), 32'd2);
      start = (i == 1);
    end
    @(posedge clk); #1 bus_gnt = 1'b1; start = 1'b0;
    wait_done("stall", 21);
    chk("stall_wr_cnt", 32'(n_wr - nw), 32'd3);
    for (int i = 0; i < 3; i++) chk("stall_ram", 32'(ram[8'h60 + 8'(i)]), 32'(ram[8'h40 + 8'(i)]));

`ifdef MEM_DMA_FILL_EN
    nr = n_rd; nw = n_wr; chk_run = 1'b0;
    start_xfer(9'h100, 9'h100, 9'd1, 1'b1, 16'h5A5A, 1'b0);
    wait_done("fill", 2);
    chk("fill_rd_cnt", 32'(n_rd - nr), 32'd0);
    chk("fill_wr_cnt", 32'(n_wr - nw), 32'd1);
    chk("fill_led", 32'(led), 32'h5A5A);
    chk_run = 1'b1;
`endif

    // Reset during the read of the second word.
    nw = n_wr;
    start_xfer(9'h080, 9'h0A0, 9'd4, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 100 && n_wr == nw; i++) begin
      @(negedge clk); #1;
    end
    wait_cmd(2'd1, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_cmd", 32'(mem_cmd), 32'd2);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rem", 32'(remaining), 32'd0);
    chk("mid_rst_req", 32'(bus_req), 32'd0);
    wrq.delete();
    repeat (20) @(negedge clk);
    #1 chk("mid_rst_wr_cnt", 32'(n_wr - nw), 32'd1);
    chk("bus_rule_viol", 32'(n_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
